if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage.
//
// Holds the PC and the IF/ID pipeline register. It selects the next PC from
// these sources, highest priority first: execute-stage branch, decode-stage
// exception, jr/jalr, j/jal, interrupt slot, stall (hold), and sequential
// increment.
//
// Build option: define IF_IRQ_EN to add the external interrupt path. That
// path has a two-flop synchroniser, a rising-edge detector, a pending flag,
// and an interrupt slot that vectors to 0x80000004. Without the macro, IRQ
// is ignored and IF_ID[64] stays 0.
//
// Ports:
//   clk            in   1  clock, rising edge
//   reset          in   1  asynchronous active-high reset
//   bubble         in   1  load-use stall, hold fetch
//   PCSrcJ         in   1  j/jal redirect
//   PCSrcJR        in   1  jr/jalr redirect
//   jump_address   in  32  j/jal target
//   jr_address     in  32  jr/jalr target
//   exception      in   1  illegal-op redirect to 0x80000008
//   branch_taken   in   1  resolved taken branch from execute
//   branch_address in  32  branch target
//   IRQ            in   1  external interrupt, asynchronous
//   instr_addr     out 32  ROM address (= PC)
//   instr_data     in  32  ROM data for instr_addr, same cycle
//   ID_Flush       out  1  = branch_taken, squashes ID/EX
//   IF_ID          out 65  {irq_slot, PC_Plus4, instruction}
// ----------------------------------------------------------------------------
module if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  logic        PCSrcJ,
    input  logic        PCSrcJR,
    input  logic [31:0] jump_address,
    input  logic [31:0] jr_address,
    input  logic        exception,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    input  logic        IRQ,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    output logic        ID_Flush,
    output logic [64:0] IF_ID
);

    localparam logic [31:0] ResetPc   = 32'h8000_0000;
    localparam logic [31:0] IrqVector = 32'h8000_0004;
    localparam logic [31:0] ExcVector = 32'h8000_0008;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [64:0] if_id_q, if_id_d;
    logic        decode_redirect;
    logic        irq_take;

    // Bit 31 is the supervisor bit. The increment never carries into it.
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

    // A stalled decode instruction will replay, so its redirects are ignored.
    assign decode_redirect = ~bubble & (exception | PCSrcJR | PCSrcJ);

`ifdef IF_IRQ_EN
    logic irq_meta_q, irq_sync_q, irq_prev_q;
    logic irq_pending_q, irq_pending_d;
    logic irq_edge;

    // Edges seen while already in supervisor space are dropped.
    assign irq_edge      = irq_sync_q & ~irq_prev_q & ~pc_q[31];
    assign irq_take      = (irq_pending_q | irq_edge) & ~branch_taken & ~decode_redirect
                           & ~bubble;
    assign irq_pending_d = (irq_pending_q | irq_edge) & ~irq_take;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_meta_q    <= 1'b0;
            irq_sync_q    <= 1'b0;
            irq_prev_q    <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            irq_meta_q    <= IRQ;
            irq_sync_q    <= irq_meta_q;
            irq_prev_q    <= irq_sync_q;
            irq_pending_q <= irq_pending_d;
        end
    end
`else
    logic unused_irq;
    assign unused_irq = IRQ;
    assign irq_take   = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_plus4;
        if_id_d = {1'b0, pc_plus4, instr_data};
        if (branch_taken) begin
            pc_d    = {branch_address[31:2], 2'b00};
            if_id_d = '0;
        end else if (decode_redirect) begin
            if_id_d = '0;
            if (exception) begin
                pc_d = ExcVector;
            end else if (PCSrcJR) begin
                pc_d = {jr_address[31:2], 2'b00};
            end else begin
                pc_d = {jump_address[31:2], 2'b00};
            end
        end else if (irq_take) begin
            // The return address is the PC that was not fetched.
            pc_d    = IrqVector;
            if_id_d = {1'b1, pc_q, 32'h0};
        end else if (bubble) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= ResetPc;
            if_id_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    assign instr_addr = pc_q;
    assign ID_Flush   = branch_taken;
    assign IF_ID      = if_id_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] ResetPc   = 32'h8000_0000;
    localparam logic [31:0] IrqVector = 32'h8000_0004;
    localparam logic [31:0] ExcVector = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bubble, PCSrcJ, PCSrcJR, exception, branch_taken, IRQ;
    logic [31:0] jump_address, jr_address, branch_address;
    logic [31:0] instr_addr, instr_data;
    logic        ID_Flush;
    logic [64:0] IF_ID;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state: architectural PC and IF/ID contents.
    logic [31:0] m_pc;
    logic [64:0] m_ifid;
    logic [31:0] n_pc;
    logic [64:0] n_ifid;

    if_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .bubble         (bubble),
        .PCSrcJ         (PCSrcJ),
        .PCSrcJR        (PCSrcJR),
        .jump_address   (jump_address),
        .jr_address     (jr_address),
        .exception      (exception),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .IRQ            (IRQ),
        .instr_addr     (instr_addr),
        .instr_data     (instr_data),
        .ID_Flush       (ID_Flush),
        .IF_ID          (IF_ID)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h3C01_1234;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    always_comb instr_data = rom(instr_addr);

    task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bubble = 0; PCSrcJ = 0; PCSrcJR = 0; exception = 0; branch_taken = 0; IRQ = 0;
        jump_address = 0; jr_address = 0; branch_address = 0;
    endtask

    // Next fetch state from the current inputs and model PC, in the
    // priority order of the fetch rules.
    task automatic predict();
        logic [31:0] seq;
        seq = {m_pc[31], m_pc[30:0] + 31'd4};
        if (branch_taken) begin
            n_pc = branch_address & ~32'd3; n_ifid = '0;
        end else if (!bubble && exception) begin
            n_pc = ExcVector; n_ifid = '0;
        end else if (!bubble && PCSrcJR) begin
            n_pc = jr_address & ~32'd3; n_ifid = '0;
        end else if (!bubble && PCSrcJ) begin
            n_pc = jump_address & ~32'd3; n_ifid = '0;
        end else if (bubble) begin
            n_pc = m_pc; n_ifid = m_ifid;
        end else begin
            n_pc = seq; n_ifid = {1'b0, seq, rom(m_pc)};
        end
    endtask

    task automatic check_outputs();
        check_eq("instr_addr", 65'(instr_addr), 65'(m_pc));
        check_eq("if_id", IF_ID, m_ifid);
        check_eq("id_flush", 65'(ID_Flush), 65'(branch_taken));
    endtask

    // One clock: check mid-cycle, advance the model over the next edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        predict();
        @(posedge clk);
        #1;
        m_pc = n_pc;
        m_ifid = n_ifid;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 0;
        m_pc = ResetPc;
        m_ifid = '0;
    endtask

    initial begin
        clr();
        reset = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_pc", 65'(instr_addr), 65'(ResetPc));
        check_eq("reset_if_id", IF_ID, 65'd0);
        release_reset();

        // Sequential fetch after reset.
        repeat (4) cycle();

        // Wrap of the user space and of the supervisor space.
        PCSrcJ = 1; jump_address = 32'h7FFF_FFF8; cycle(); clr();
        repeat (3) cycle();
        PCSrcJR = 1; jr_address = 32'hFFFF_FFFB; cycle(); clr();
        repeat (3) cycle();

        // Two-cycle stall at 0x10.
        PCSrcJ = 1; jump_address = 32'h0000_0010; cycle(); clr();
        bubble = 1; cycle(); cycle(); bubble = 0;
        repeat (3) cycle();

        // Jump, then the same jump suppressed by a stall.
        PCSrcJ = 1; jump_address = 32'h0000_0100; cycle(); clr(); cycle();
        bubble = 1; PCSrcJ = 1; jump_address = 32'h0000_0200; cycle(); cycle(); clr();
        cycle();

        // Branch beats stall and JR.
        branch_taken = 1; branch_address = 32'h0000_0040; PCSrcJR = 1; jr_address = 32'h500;
        bubble = 1; cycle(); clr(); cycle();

        // J with JR, exception with JR, exception under stall, misaligned branch.
        PCSrcJ = 1; jump_address = 32'h600; PCSrcJR = 1; jr_address = 32'h700; cycle(); clr();
        cycle();
        exception = 1; PCSrcJR = 1; jr_address = 32'h900; cycle(); clr(); cycle();
        exception = 1; bubble = 1; cycle(); clr(); cycle();
        branch_taken = 1; branch_address = 32'h0000_0123; cycle(); clr(); cycle();

        // Asynchronous reset in the middle of a stalled redirect.
        bubble = 1; PCSrcJ = 1; jump_address = 32'h300; cycle();
        #2 reset = 1;
        @(negedge clk);
        check_eq("midrun_reset_pc", 65'(instr_addr), 65'(ResetPc));
        check_eq("midrun_reset_if_id", IF_ID, 65'd0);
        clr();
        release_reset();
        repeat (2) cycle();

`ifdef IF_IRQ_EN
        begin
            int k;
            logic found;
            PCSrcJ = 1; jump_address = 32'h0000_0020; cycle(); clr();
            IRQ = 1;
            @(negedge clk);
            check_eq("irq_start_pc", 65'(instr_addr), 65'h20);
            @(posedge clk);
            #1 IRQ = 0;
            found = 0;
            k = 0;
            while (!found && k < 6) begin
                k++;
                @(negedge clk);
                if (instr_addr == IrqVector) found = 1;
            end
            check_eq("irq_taken_within_3", 65'(found && k <= 3), 65'd1);
            m_pc = IrqVector;
            m_ifid = {1'b1, 32'h20 + 32'(4 * (k - 1)), 32'h0};
            check_eq("irq_if_id", IF_ID, m_ifid);
            predict();
            @(posedge clk);
            #1;
            m_pc = n_pc;
            m_ifid = n_ifid;
            // A pulse while in supervisor space must be dropped.
            IRQ = 1; cycle(); IRQ = 0;
            repeat (6) cycle();
        end
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            branch_taken = ($urandom_range(0, 15) == 0);
            exception    = ($urandom_range(0, 31) == 0);
            PCSrcJR      = ($urandom_range(0, 9) == 0);
            PCSrcJ       = ($urandom_range(0, 7) == 0);
            bubble       = ($urandom_range(0, 4) == 0);
            branch_address = $urandom;
            jr_address     = $urandom;
            jump_address   = ($urandom_range(0, 2) == 0)
                             ? {$urandom_range(0, 1) == 1, 27'h7FF_FFFF, 4'($urandom)}
                             : $urandom;
`ifdef IF_IRQ_EN
            IRQ = 0;
`else
            IRQ = $urandom_range(0, 1) == 1;
`endif
            cycle();
        end
        clr();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
